// File: rtl/cordic_pkg.sv
// Shared types and elaboration-time constant generators for the iterative sine/cosine CORDIC.
// Table values are computed in real arithmetic and rounded to nearest at the requested fraction width.
package cordic_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ROTATE = 1'b1
  } state_t;

  function automatic longint to_fixed(input real v, input int fb);
    real s;
    s = v * (2.0 ** fb);
    if (s >= 0.0) return longint'($rtoi(s + 0.5));
    return -longint'($rtoi(-s + 0.5));
  endfunction

  function automatic real atan_pow2(input int i);
    case (i)
      0:  return 0.7853981633974483;
      1:  return 0.4636476090008061;
      2:  return 0.24497866312686414;
      3:  return 0.12435499454676144;
      4:  return 0.06241880999595735;
      5:  return 0.031239833430268277;
      6:  return 0.015623728620476831;
      7:  return 0.007812341060101111;
      8:  return 0.0039062301319669718;
      9:  return 0.0019531225164788188;
      10: return 0.0009765621895593195;
      11: return 0.0004882812111948983;
      12: return 0.00024414062014936177;
      13: return 0.00012207031189367021;
      14: return 0.00006103515617420877;
      15: return 0.000030517578115526096;
      16: return 0.000015258789061315762;
      17: return 0.00000762939453110197;
      18: return 0.000003814697265606496;
      19: return 0.000001907348632810187;
      20: return 0.0000009536743164059608;
      // Beyond here atan(x) equals x well below one LSB of any practical width
      default: return 2.0 ** (-i);
    endcase
  endfunction

  function automatic longint atan_fixed(input int i, input int fb);
    return to_fixed(atan_pow2(i), fb);
  endfunction

  // Gain correction 1/prod(sqrt(1+2^-2i)); the square root uses Newton steps
  function automatic longint k_fixed(input int iter, input int fb);
    real p;
    real s;
    p = 1.0;
    for (int i = 0; i < iter; i++) p = p * (1.0 + 2.0 ** (-2 * i));
    s = p;
    for (int n = 0; n < 40; n++) s = 0.5 * (s + p / s);
    return to_fixed(1.0 / s, fb);
  endfunction

  function automatic longint half_pi_fixed(input int fb);
    return to_fixed(1.5707963267948966, fb);
  endfunction

  localparam int     DEF_FRAC = 19;
  localparam longint HALF_PI  = half_pi_fixed(DEF_FRAC + 2);

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational atan(2^-i) lookup for the CORDIC rotation; unused slots past ITER read zero.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int DW   = 24,
  parameter int FB   = 21,
  parameter int ITER = 16,
  parameter int IW   = 4
) (
  input  logic [IW-1:0]        idx,
  output logic signed [DW-1:0] atan_val
);

  logic signed [DW-1:0] rom_tbl [2**IW];

  generate
    for (genvar gi = 0; gi < 2**IW; gi++) begin : g_rom
      if (gi < ITER) begin : g_used
        assign rom_tbl[gi] = DW'(atan_fixed(gi, FB));
      end else begin : g_pad
        assign rom_tbl[gi] = '0;
      end
    end
  endgenerate

  assign atan_val = rom_tbl[idx];

endmodule

// File: rtl/cordic_sincos_iter.sv
// Iterative CORDIC sine/cosine over [-pi, pi): quadrant pre-rotation, one micro-rotation per clock,
// two guard bits internally, start/ready/done handshake.
module cordic_sincos_iter
  import cordic_pkg::*;
#(
  parameter int WIDTH = 22,
  parameter int ITER  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] angle,
  output logic                    ready,
  output logic                    done,
  output logic signed [WIDTH-1:0] cos_out,
  output logic signed [WIDTH-1:0] sin_out
);

  localparam int FRAC = WIDTH - 3;
  localparam int FB   = FRAC + 2;
  localparam int DW   = WIDTH + 2;
  localparam int IW   = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic signed [DW-1:0] K_C  = DW'(k_fixed(ITER, FB));
  localparam logic signed [DW-1:0] HP_C = DW'(half_pi_fixed(FB));
  localparam logic [IW-1:0]        LAST = IW'(ITER - 1);

  state_t               state_q, state_d;
  logic signed [DW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [IW-1:0]        i_q, i_d;
  logic                 done_q, done_d;
  logic signed [WIDTH-1:0] cos_q, cos_d, sin_q, sin_d;

  logic signed [DW-1:0] a_ext, atan_val;
  logic signed [DW-1:0] x_sh, y_sh, x_n, y_n, z_n;

  cordic_atan_rom #(
    .DW  (DW),
    .FB  (FB),
    .ITER(ITER),
    .IW  (IW)
  ) u_atan_rom (
    .idx     (i_q),
    .atan_val(atan_val)
  );

  always_comb begin
    a_ext = {angle, 2'b00};
    x_sh  = x_q >>> i_q;
    y_sh  = y_q >>> i_q;
    if (!z_q[DW-1]) begin
      x_n = x_q - y_sh;
      y_n = y_q + x_sh;
      z_n = z_q - atan_val;
    end else begin
      x_n = x_q + y_sh;
      y_n = y_q - x_sh;
      z_n = z_q + atan_val;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    done_d  = 1'b0;
    cos_d   = cos_q;
    sin_d   = sin_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ROTATE;
          i_d     = '0;
          // Outer quadrants start from +/-90 degrees so the residual stays inside CORDIC convergence
          if (a_ext > HP_C) begin
            x_d = '0;
            y_d = K_C;
            z_d = a_ext - HP_C;
          end else if (a_ext < -HP_C) begin
            x_d = '0;
            y_d = -K_C;
            z_d = a_ext + HP_C;
          end else begin
            x_d = K_C;
            y_d = '0;
            z_d = a_ext;
          end
        end
      end
      ROTATE: begin
        x_d = x_n;
        y_d = y_n;
        z_d = z_n;
        i_d = i_q + 1'b1;
        if (i_q == LAST) begin
          state_d = IDLE;
          i_d     = '0;
          done_d  = 1'b1;
          cos_d   = x_n[DW-1:2];
          sin_d   = y_n[DW-1:2];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      done_q  <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      done_q  <= done_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign done    = done_q;
  assign cos_out = cos_q;
  assign sin_out = sin_q;

endmodule

// File: tb/tb_cordic_sincos_iter.sv
// Directed bench for cordic_sincos_iter: reset state, accuracy on hand-computed angles, handshake timing,
// ignored mid-rotation start, back-to-back throughput and mid-operation reset abort.
module tb_cordic_sincos_iter;

  localparam int WIDTH = 22;
  localparam int ITER  = 16;
  localparam int TOL   = 24;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start;
  logic signed [WIDTH-1:0] angle;
  logic                    ready;
  logic                    done;
  logic signed [WIDTH-1:0] cos_out;
  logic signed [WIDTH-1:0] sin_out;

  int checks = 0;
  int errors = 0;

  cordic_sincos_iter #(
    .WIDTH(WIDTH),
    .ITER (ITER)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .angle  (angle),
    .ready  (ready),
    .done   (done),
    .cos_out(cos_out),
    .sin_out(sin_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp, input int tol);
    logic ok;
    checks++;
    ok = ((obs - exp) <= tol) && ((exp - obs) <= tol);
    assert (ok === 1'b1)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
    end
  endtask

  // Issue one operation; optionally pulse start again at cycle 'poke' of the rotation.
  // Returns edges-to-done and the number of ROTATE cycles where ready was wrongly high.
  task automatic op(input int a, input int poke, input int poke_a, output int lat, output int bad);
    angle = WIDTH'(a);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    bad = 0;
    while (!done && lat < 40) begin
      if (lat == poke) begin
        start = 1'b1;
        angle = WIDTH'(poke_a);
      end
      @(posedge clk);
      #1 start = 1'b0;
      lat++;
      if (!done && ready) bad++;
    end
  endtask

  int vec_a   [6] = '{0, 262144, 1310720, -1310720, -262144, 823550};
  int vec_cos [6] = '{524288, 460105, -420028, -420028, 460105, 0};
  int vec_sin [6] = '{0, 251360, 313771, -313771, -251360, 524288};

  initial begin
    int lat;
    int lat2;
    int bad;
    int pulses;

    reset = 1'b1;
    start = 1'b0;
    angle = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", int'(ready), 1, 0);
    check("reset_done", int'(done), 0, 0);
    check("reset_cos", int'(cos_out), 0, 0);
    check("reset_sin", int'(sin_out), 0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      op(vec_a[v], -1, 0, lat, bad);
      $display("op angle=%0d latency=%0d cos=%0d sin=%0d", vec_a[v], lat, cos_out, sin_out);
      check($sformatf("latency_%0d", v), lat, ITER, 0);
      check($sformatf("ready_low_%0d", v), bad, 0, 0);
      check($sformatf("ready_at_done_%0d", v), int'(ready), 1, 0);
      check($sformatf("cos_%0d", v), int'(cos_out), vec_cos[v], TOL);
      check($sformatf("sin_%0d", v), int'(sin_out), vec_sin[v], TOL);
      @(posedge clk);
      #1;
      check($sformatf("done_pulse_%0d", v), int'(done), 0, 0);
      check($sformatf("cos_hold_%0d", v), int'(cos_out), vec_cos[v], TOL);
    end

    // Second start mid-rotation must be ignored; then chain a start in the done cycle
    op(262144, 5, -1310720, lat, bad);
    $display("op angle=262144 poked latency=%0d cos=%0d sin=%0d", lat, cos_out, sin_out);
    check("poke_latency", lat, ITER, 0);
    check("poke_ready_low", bad, 0, 0);
    check("poke_cos", int'(cos_out), 460105, TOL);
    check("poke_sin", int'(sin_out), 251360, TOL);
    op(1310720, -1, 0, lat2, bad);
    $display("op angle=1310720 back-to-back gap=%0d cos=%0d sin=%0d", lat2 + 1, cos_out, sin_out);
    check("b2b_gap", lat2 + 1, ITER + 1, 0);
    check("b2b_cos", int'(cos_out), -420028, TOL);
    check("b2b_sin", int'(sin_out), 313771, TOL);
    @(posedge clk);
    #1;

    // Abort with reset while iteration 7 is in flight
    angle = WIDTH'(262144);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    $display("reset abort ready=%0d done=%0d cos=%0d sin=%0d", ready, done, cos_out, sin_out);
    check("abort_ready", int'(ready), 1, 0);
    check("abort_done", int'(done), 0, 0);
    check("abort_cos", int'(cos_out), 0, 0);
    check("abort_sin", int'(sin_out), 0, 0);
    pulses = 0;
    repeat (24) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0, 0);

    // Reset and start together: reset wins, unit stays idle
    reset = 1'b1;
    start = 1'b1;
    angle = WIDTH'(262144);
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    $display("reset+start ready=%0d", ready);
    check("reset_beats_start", int'(ready), 1, 0);
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("reset_beats_start_no_done", pulses, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
